// File: rtl/y_fifo.sv
// y_fifo: first-word fall-through buffer between the transform stage (its y output)
// and a downstream consumer. Keeps a sticky overflow flag for writes attempted while
// full, plus a 16-bit running count of accepted words.
module y_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [15:0]              total
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      total_q, total_d;
  logic             wr_en, rd_en;

  // Handshake decode; an edge during reset must not touch storage.
  always_comb begin
    in_ready  = (count_q != CntFull);
    out_valid = (count_q != '0);
    wr_en     = in_valid && in_ready && !rst;
    rd_en     = out_valid && out_ready;
    out_data  = out_valid ? mem_q[rptr_q] : '0;
    count     = count_q;
    overflow  = overflow_q;
    total     = total_q;
  end

  // Next-state for pointers, occupancy, overflow flag and accepted-word total.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    total_d    = total_q;
    mem_d      = mem_q;
    if (wr_en) begin
      mem_d[wptr_q] = in_data;
      wptr_d        = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
      total_d       = total_q + 16'd1;
    end
    if (rd_en) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over clear so a concurrent drop is never lost.
    if (in_valid && (count_q == CntFull)) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_y_fifo.sv
// Directed self-checking bench for y_fifo (WIDTH=8, DEPTH=4).
module tb_y_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] total;

  int checks = 0;
  int failures = 0;

  y_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .total     (total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] burst [4];

  initial begin
    burst[0] = 8'hAA; burst[1] = 8'hCC; burst[2] = 8'h33; burst[3] = 8'h0F;
    rst = 1'b1; in_data = 8'h99; in_valid = 1'b1; out_ready = 1'b1; clr_ovf = 1'b0;
    step();
    step();
    // Reset state; the in_valid handshake during reset must be ignored.
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_total", total, 0);
    chk("rst_out_data", out_data, 0);

    // First write on the first edge after reset; no same-cycle bypass.
    rst = 1'b0; in_data = 8'h55; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("nobypass_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("w55_valid", out_valid, 1);
    chk("w55_data", out_data, 8'h55);
    chk("w55_count", count, 1);
    chk("w55_total", total, 1);

    // Drain, then a read on empty has no effect.
    out_ready = 1'b1;
    step();
    chk("drain55_count", count, 0);
    chk("drain55_data", out_data, 0);
    step();
    chk("emptyread_count", count, 0);
    chk("emptyread_total", total, 1);

    // Fill to full.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = burst[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_total", total, 5);

    // Attempted write while full is dropped and flagged.
    in_data = 8'hEE; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_total", total, 5);
    chk("ovf_head", out_data, 8'hAA);
    clr_ovf = 1'b1;
    step();
    chk("ovf_clr", overflow, 0);
    // Set wins over a concurrent clear.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ovf_setwins", overflow, 1);
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr2", overflow, 0);

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_data", i), out_data, burst[i]);
      step();
    end
    chk("drained_valid", out_valid, 0);
    chk("drained_count", count, 0);

    // Streaming 10 words with simultaneous read; pointers wrap.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h10 + 8'(i);
      step();
      chk($sformatf("stream%0d_data", i), out_data, 8'h10 + i);
      chk($sformatf("stream%0d_count", i), count, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_count", count, 0);
    chk("stream_total", total, 15);

    // Full plus simultaneous read and write: read only.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + 8'(i);
      step();
    end
    in_data = 8'hEE; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullrw_count", count, 3);
    chk("fullrw_ovf", overflow, 1);
    chk("fullrw_total", total, 19);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("fullrw_drain%0d", i), out_data, 8'hA0 + i);
      step();
    end
    chk("fullrw_empty", out_valid, 0);
    out_ready = 1'b0;

    // Asynchronous reset mid-stream with two words stored.
    in_valid = 1'b1;
    in_data = 8'hB0; step();
    in_data = 8'hB1; step();
    in_valid = 1'b0;
    chk("pre_rst_count", count, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_total", total, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_in_ready", in_ready, 1);
    step();
    rst = 1'b0; in_data = 8'hC5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_count", count, 1);
    chk("post_rst_data", out_data, 8'hC5);
    chk("post_rst_total", total, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
